// File: rtl/mac_pipe.sv
// rtl/mac_pipe.sv - pipelined signed multiply-accumulate with valid/ready handshake
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   input beat handshake (in_ready = !stall)
//   mode, acc_clr         0 = a*b+c; 1 = acc += a*b (acc_clr restarts the sum)
//   a, b, c, in_last      operands and sideband tag
//   out_valid / out_ready result handshake
//   result, out_ovf       narrowed result and saturate/wrap flag
//   out_last              in_last carried alongside its beat
module mac_pipe #(
    parameter int IN_W     = 16,
    parameter int C_W      = 32,
    parameter int ACC_W    = 40,
    parameter int OUT_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic             acc_clr,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic [C_W-1:0]   c,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic             out_ovf,
    output logic             out_last
);
    localparam int P_W = 2 * IN_W;
    localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    // The whole pipe freezes while a result sits unaccepted at the output.
    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Stage 1: operand capture
    logic                   s1_valid, s1_mode, s1_clr, s1_last;
    logic signed [IN_W-1:0] s1_a, s1_b;
    logic signed [C_W-1:0]  s1_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_clr   <= 1'b0;
            s1_last  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            s1_mode  <= mode;
            s1_clr   <= acc_clr;
            s1_last  <= in_last;
            s1_a     <= a;
            s1_b     <= b;
            s1_c     <= c;
        end
    end

    // Stage 2: full-width product. Operands are sign-extended to P_W first so
    // that (-2^(IN_W-1))^2 is exact.
    logic signed [P_W-1:0] a_ext, b_ext;
    assign a_ext = P_W'(s1_a);
    assign b_ext = P_W'(s1_b);

    logic                  s2_valid, s2_mode, s2_clr, s2_last;
    logic signed [P_W-1:0] s2_prod;
    logic signed [C_W-1:0] s2_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_mode  <= 1'b0;
            s2_clr   <= 1'b0;
            s2_last  <= 1'b0;
            s2_prod  <= '0;
            s2_c     <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            s2_clr   <= s1_clr;
            s2_last  <= s1_last;
            s2_prod  <= a_ext * b_ext;
            s2_c     <= s1_c;
        end
    end

    // Stage 3: add / accumulate, then narrow to OUT_W
    logic signed [ACC_W-1:0] acc, prod_ext, c_ext, sum;
    assign prod_ext = ACC_W'(s2_prod);
    assign c_ext    = ACC_W'(s2_c);

    always_comb begin
        sum = prod_ext + c_ext;
        if (s2_mode) begin
            sum = s2_clr ? prod_ext : acc + prod_ext;
        end
    end

    // sum fits in OUT_W when every bit from the OUT_W sign bit upward agrees.
    logic [ACC_W-OUT_W:0] sum_hi;
    logic                 fits;
    assign sum_hi = sum[ACC_W-1:OUT_W-1];
    assign fits   = (&sum_hi) || !(|sum_hi);

    logic [OUT_W-1:0] res_n;
    logic             ovf_n;

    always_comb begin
        res_n = sum[OUT_W-1:0];
        ovf_n = 1'b0;
        if (!fits) begin
            ovf_n = 1'b1;
            if (SATURATE != 0) begin
                res_n = sum[ACC_W-1] ? MIN_NEG : MAX_POS;
            end
        end
    end

    // Only real accumulate beats touch the accumulator; bubbles and mul_add
    // beats leave a running sum intact.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (!stall && s2_valid && s2_mode) begin
            acc <= sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            out_ovf   <= 1'b0;
            out_last  <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                result   <= res_n;
                out_ovf  <= ovf_n;
                out_last <= s2_last;
            end
        end
    end
endmodule

// File: tb/tb_mac_pipe.sv
// tb/tb_mac_pipe.sv - self-checking bench for mac_pipe (saturating and wrapping builds)
module tb_mac_pipe;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, mode, acc_clr, in_last, out_ready;
    logic [15:0] a, b;
    logic [31:0] c;
    logic        in_ready, out_valid, out_ovf, out_last;
    logic [31:0] result;
    logic        in_ready_w, out_valid_w, out_ovf_w, out_last_w;
    logic [31:0] result_w;

    always #5 clk = ~clk;

    mac_pipe #(.IN_W(16), .C_W(32), .ACC_W(40), .OUT_W(32), .SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .acc_clr(acc_clr), .a(a), .b(b), .c(c), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_ovf(out_ovf), .out_last(out_last));

    mac_pipe #(.IN_W(16), .C_W(32), .ACC_W(40), .OUT_W(32), .SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .mode(mode), .acc_clr(acc_clr), .a(a), .b(b), .c(c), .in_last(in_last),
        .out_valid(out_valid_w), .out_ready(out_ready), .result(result_w),
        .out_ovf(out_ovf_w), .out_last(out_last_w));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs computed when a beat is accepted.
    typedef struct packed {
        logic [31:0] rs;
        logic        os;
        logic [31:0] rw;
        logic        ow;
        logic        last;
    } exp_t;

    exp_t        q[$];
    logic [33:0] got_s[$];
    logic [33:0] got_w[$];
    longint      macc = 0;
    bit          mon_on = 0;

    function automatic longint w40(input longint x);
        return (x <<< 24) >>> 24;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            macc = 0;
        end else if (in_valid && in_ready) begin
            longint p, s;
            exp_t   e;
            p = longint'($signed(a)) * longint'($signed(b));
            if (!mode)        s = w40(p + longint'($signed(c)));
            else if (acc_clr) s = p;
            else              s = w40(macc + p);
            if (mode) macc = s;
            if (s >= -64'sd2147483648 && s <= 64'sd2147483647) begin
                e.rs = s[31:0]; e.os = 1'b0; e.rw = s[31:0]; e.ow = 1'b0;
            end else begin
                e.rs = (s < 0) ? 32'h8000_0000 : 32'h7fff_ffff;
                e.os = 1'b1; e.rw = s[31:0]; e.ow = 1'b1;
            end
            e.last = in_last;
            q.push_back(e);
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res = '0;
    always @(negedge clk) begin
        if (mon_on) begin
            chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            chk("valid_pair", 32'(out_valid_w), 32'(out_valid));
            if (prev_stall && rst_n) chk("stall_hold", result, prev_res);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    chk("res_sat", result, q[0].rs);
                    chk("ovf_sat", 32'(out_ovf), 32'(q[0].os));
                    chk("res_wrap", result_w, q[0].rw);
                    chk("ovf_wrap", 32'(out_ovf_w), 32'(q[0].ow));
                    chk("last", 32'(out_last), 32'(q[0].last));
                    if (out_ready) begin
                        void'(q.pop_front());
                        got_s.push_back({out_last, out_ovf, result});
                        got_w.push_back({out_last_w, out_ovf_w, result_w});
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
        end
    end

    task automatic send(input logic m, input logic clr, input int av, input int bv,
                        input int cv, input logic lst);
        int n;
        logic ok;
        mode = m; acc_clr = clr; a = av[15:0]; b = bv[15:0]; c = cv; in_last = lst;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready && rst_n;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) chk("send_timeout", 32'(n), 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic chk_out(input string nm, input int i, input logic [31:0] r,
                           input logic o, input logic l, input bit from_w);
        logic [33:0] g;
        g = 'x;
        if (!from_w && i < got_s.size()) g = got_s[i];
        if (from_w && i < got_w.size()) g = got_w[i];
        chk({nm, "_res"}, g[31:0], r);
        chk({nm, "_ovf"}, 32'(g[32]), 32'(o));
        chk({nm, "_last"}, 32'(g[33]), 32'(l));
    endtask

    function automatic int rnd_in();
        int r;
        case ($urandom_range(0, 7))
            0: return -32768;
            1: return 32767;
            default: begin
                r = int'($urandom);
                return (r <<< 16) >>> 16;
            end
        endcase
    endfunction

    bit done;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; acc_clr = 1'b0; in_last = 1'b0;
        out_ready = 1'b1; a = '0; b = '0; c = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        mon_on = 1;

        // mul_add with explicit latency
        send(1'b0, 1'b0, -5, 3, 10, 1'b0);
        chk("lat_e0", 32'(out_valid), 32'd0);
        send(1'b0, 1'b0, 1000, 1000, 0, 1'b0);
        chk("lat_e1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_e2_valid", 32'(out_valid), 32'd1);
        chk("lat_e2_res", result, 32'hFFFF_FFFB);
        @(posedge clk); #1;
        chk("lat_e3_res", result, 32'd1000000);
        drain();
        chk_out("t1_0", 0, 32'hFFFF_FFFB, 1'b0, 1'b0, 0);
        chk_out("t1_1", 1, 32'd1000000, 1'b0, 1'b0, 0);

        // accumulate with last tag
        got_s.delete(); got_w.delete();
        send(1'b1, 1'b1, 2, 3, 0, 1'b0);
        send(1'b1, 1'b0, 4, 5, 0, 1'b0);
        send(1'b1, 1'b0, -1, 6, 0, 1'b1);
        drain();
        chk_out("t2_0", 0, 32'd6, 1'b0, 1'b0, 0);
        chk_out("t2_1", 1, 32'd26, 1'b0, 1'b0, 0);
        chk_out("t2_2", 2, 32'd20, 1'b0, 1'b1, 0);

        // extreme product and saturation vs wrap
        got_s.delete(); got_w.delete();
        send(1'b1, 1'b1, -32768, -32768, 0, 1'b0);
        send(1'b1, 1'b0, -32768, -32768, 0, 1'b0);
        drain();
        chk_out("t3_s0", 0, 32'd1073741824, 1'b0, 1'b0, 0);
        chk_out("t3_s1", 1, 32'd2147483647, 1'b1, 1'b0, 0);
        chk_out("t3_w0", 0, 32'd1073741824, 1'b0, 1'b0, 1);
        chk_out("t3_w1", 1, 32'h8000_0000, 1'b1, 1'b0, 1);

        // backpressure: 4-cycle stall once out_valid rises
        got_s.delete(); got_w.delete();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(1'b0, 1'b0, i + 1, 10, i, 1'b0);
            end
            begin
                int n = 0;
                while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
                chk("bp_valid_rose", 32'(out_valid), 32'd1);
                for (int k = 0; k < 4; k++) begin
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 32'(got_s.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk_out("t4", i, 32'(11 * i + 10), 1'b0, 1'b0, 0);

        // interleaved mul_add and ignored acc_clr in mode 0
        got_s.delete(); got_w.delete();
        send(1'b1, 1'b1, 5, 2, 0, 1'b0);
        send(1'b0, 1'b0, 7, 2, 5, 1'b0);
        send(1'b1, 1'b0, 3, 1, 0, 1'b0);
        send(1'b0, 1'b1, 2, 2, 0, 1'b0);
        send(1'b1, 1'b0, 1, 1, 0, 1'b0);
        drain();
        chk_out("t5_0", 0, 32'd10, 1'b0, 1'b0, 0);
        chk_out("t5_1", 1, 32'd19, 1'b0, 1'b0, 0);
        chk_out("t5_2", 2, 32'd13, 1'b0, 1'b0, 0);
        chk_out("t5_3", 3, 32'd4, 1'b0, 1'b0, 0);
        chk_out("t5_4", 4, 32'd14, 1'b0, 1'b0, 0);

        // randomized traffic with random backpressure
        done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                         rnd_in(), rnd_in(), int'($urandom), 1'($urandom_range(0, 1)));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // reset with two beats in flight, then accumulate from a cleared sum
        send(1'b1, 1'b1, 100, 100, 0, 1'b0);
        send(1'b0, 1'b0, 9, 9, 9, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        got_s.delete(); got_w.delete();
        send(1'b1, 1'b0, 4, 4, 0, 1'b0);
        drain();
        chk_out("t7", 0, 32'd16, 1'b0, 1'b0, 0);
        chk("t7_count", 32'(got_s.size()), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
